// File: rtl/serial_adder_ctrl_if.sv
// Handshake/result bundle between a requester and the bit-serial adder controller.
// The requester drives the operands and start; the adder returns busy/done and the result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell walks WIDTH bit-slices LSB first.
// state | meaning
// IDLE  | waiting for start; operands and cin latched on an accepted start
// SHIFT | one bit-slice per edge, busy high; result published on the last slice
// DONE  | one-cycle done pulse, then unconditionally back to IDLE
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_shift;

  serial_adder_fa u_fulladder (
    .a  (op_a_q[0]),
    .b  (op_b_q[0]),
    .ci (cy_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so that after WIDTH slices bit 0 holds the LSB.
  always_comb begin
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_a_d  = bus.a;
          op_b_d  = bus.b;
          cy_d    = bus.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        op_a_d = op_a_q >> 1;
        op_b_d = op_b_q >> 1;
        cy_d   = fa_co;
        res_d  = res_shift;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Only the completed result ever reaches the sum output.
          sum_d   = res_shift;
          carry_d = fa_co;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
endmodule

// Single one-bit full-adder cell shared across all bit-slices.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: stimulus queues expected results, per-DUT monitors check on done.
module tb_serial_adder_ctrl;
  localparam int W  = 8;
  localparam int W1 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W))  bus8 ();
  serial_adder_ctrl_if #(.WIDTH(W1)) bus1 ();

  serial_adder_ctrl #(.WIDTH(W))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(W1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    int         due;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   run8     = 0;
  int   run1     = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      run8 = 0;
    end else begin
      if (bus8.busy) run8++;
      else if (run8 != 0) begin
        check("busy8_len", run8, W);
        run8 = 0;
      end
      if (bus8.done) begin
        check("done8_busy_excl", bus8.busy, 0);
        if (q8.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done8_unexpected actual=done_high required=no_done (cycle %0d)", cyc);
        end else begin
          e8 = q8.pop_front();
          check("sum8", bus8.sum, e8.sum);
          check("carry8", bus8.carry, e8.carry);
          check("done8_cycle", cyc, e8.due);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      run1 = 0;
    end else begin
      if (bus1.busy) run1++;
      else if (run1 != 0) begin
        check("busy1_len", run1, W1);
        run1 = 0;
      end
      if (bus1.done) begin
        check("done1_busy_excl", bus1.busy, 0);
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done1_unexpected actual=done_high required=no_done (cycle %0d)", cyc);
        end else begin
          e1 = q1.pop_front();
          check("sum1", bus1.sum, e1.sum[0]);
          check("carry1", bus1.carry, e1.carry);
          check("done1_cycle", cyc, e1.due);
        end
      end
    end
  end

  // Called at a falling edge; returns W+2 falling edges later, when the DUT is back in IDLE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] es, input logic ec, input bit scramble);
    exp_t e;
    e.sum   = es;
    e.carry = ec;
    e.due   = cyc + 1 + W;
    q8.push_back(e);
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    if (scramble) begin
      bus8.a   = 8'h00;
      bus8.b   = 8'h00;
      bus8.cin = 1'b1;
    end
    repeat (W) @(negedge clk);
  endtask

  task automatic op1(input logic a, input logic b, input logic cin,
                     input logic es, input logic ec);
    exp_t e;
    e.sum   = {7'd0, es};
    e.carry = ec;
    e.due   = cyc + 1 + W1;
    q1.push_back(e);
    bus1.a     = a;
    bus1.b     = b;
    bus1.cin   = cin;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (W1 + 1) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fa_sum;
    logic [7:0] fa_cy;
    logic [2:0] idx;
    int         base;
    exp_t       e;
    fa_sum = 8'b1001_0110;
    fa_cy  = 8'b1110_1000;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy8",  bus8.busy,  0);
    check("rst_done8",  bus8.done,  0);
    check("rst_sum8",   bus8.sum,   0);
    check("rst_carry8", bus8.carry, 0);
    check("rst_busy1",  bus1.busy,  0);
    check("rst_sum1",   bus1.sum,   0);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0);
    op8(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b1);
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0);

    // start held high: restarts every W+2 edges
    base = cyc;
    for (int i = 0; i < 3; i++) begin
      e.sum   = 8'h30;
      e.carry = 1'b0;
      e.due   = base + 1 + W + i * (W + 2);
      q8.push_back(e);
    end
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
    repeat (3 * (W + 2)) @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);

    // reset during the fourth SHIFT cycle; no result may follow
    bus8.a = 8'h11; bus8.b = 8'h22; bus8.cin = 1'b1; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy8", bus8.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy8",  bus8.busy,  0);
    check("midrst_done8",  bus8.done,  0);
    check("midrst_sum8",   bus8.sum,   0);
    check("midrst_carry8", bus8.carry, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    op8(8'h3C, 8'hC4, 1'b1, 8'h01, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      op1(idx[2], idx[1], idx[0], fa_sum[i], fa_cy[i]);
    end

    repeat (3) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
